// File: rtl/ebab_reg_responder.sv
// ebab_reg_responder
//   Responder end of the External Bus to Avalon Bridge link. Serves single
//   read/write requests from a bank of 2**ADDR_WIDTH registers. Each request
//   completes WAIT_STATES cycles after acceptance with a one-cycle ack pulse.
//
// Ports
//   clk         rising-edge system clock
//   reset       synchronous, active-high reset
//   addr        word address of the request
//   write_data  write payload
//   read_en     read request strobe
//   write_en    write request strobe (wins over read_en)
//   byte_en     per-byte write enables, bit i covers data[8i+7:8i]
//   read_data   read result, valid from the ack cycle of a read until the next read ack
//   ack         one-cycle completion pulse
//   busy        high from the cycle after acceptance through the ack cycle
module ebab_reg_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int WAIT_STATES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic                    read_en,
  input  logic                    write_en,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    ack,
  output logic                    busy
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic                  wr_q, wr_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] bank_q [DEPTH];

  function automatic logic [DATA_WIDTH-1:0] byte_merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [BE_W-1:0]       be
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (read_en || write_en) begin
          addr_d  = addr;
          wdata_d = write_data;
          be_d    = byte_en;
          wr_d    = write_en;
          busy_d  = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            // zero wait states: the ack cycle follows acceptance directly,
            // so the read uses the live address rather than the latched one
            state_d = ACK;
            ack_d   = 1'b1;
            if (!write_en) rdata_d = bank_q[addr];
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACK;
          ack_d   = 1'b1;
          if (!wr_q) rdata_d = bank_q[addr_q];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      // write commits at the edge that ends the ack cycle
      if (state_q == ACK && wr_q)
        bank_q[addr_q] <= byte_merge(bank_q[addr_q], wdata_q, be_q);
    end
  end

  assign read_data = rdata_q;
  assign ack       = ack_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ebab_reg_responder.sv
// Bench for ebab_reg_responder: instance 0 runs with WAIT_STATES=2,
// instance 1 with WAIT_STATES=0. Expected acks are queued per instance at
// request time and retired by a negedge monitor.
module tb_ebab_reg_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [2];
  logic [3:0]  addr_s  [2];
  logic [31:0] wd_s    [2];
  logic        rd_s    [2];
  logic        wr_s    [2];
  logic [3:0]  be_s    [2];
  logic [31:0] rdata_s [2];
  logic        ack_s   [2];
  logic        busy_s  [2];

  ebab_reg_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .WAIT_STATES(2)) dut_a (
    .clk(clk), .reset(rst_s[0]), .addr(addr_s[0]), .write_data(wd_s[0]),
    .read_en(rd_s[0]), .write_en(wr_s[0]), .byte_en(be_s[0]),
    .read_data(rdata_s[0]), .ack(ack_s[0]), .busy(busy_s[0]));

  ebab_reg_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .WAIT_STATES(0)) dut_b (
    .clk(clk), .reset(rst_s[1]), .addr(addr_s[1]), .write_data(wd_s[1]),
    .read_en(rd_s[1]), .write_en(wr_s[1]), .byte_en(be_s[1]),
    .read_data(rdata_s[1]), .ack(ack_s[1]), .busy(busy_s[1]));

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
    int          ack_cyc;
  } sb_t;

  sb_t         sb0[$];
  sb_t         sb1[$];
  logic [31:0] mdl     [2][16];
  logic [31:0] last_rd [2];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ws(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic push(input int i, input sb_t e);
    if (i == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic mon_ack(input int i);
    sb_t   e;
    string p;
    p = (i == 0) ? "a" : "b";
    if ((i == 0 && sb0.size() == 0) || (i == 1 && sb1.size() == 0)) begin
      chk({p, "_unexpected_ack"}, ack_s[i], 0);
      return;
    end
    if (i == 0) e = sb0.pop_front();
    else        e = sb1.pop_front();
    chk({p, "_ack_cycle"}, cyc, e.ack_cyc);
    chk({p, "_busy_in_ack"}, busy_s[i], 1);
    if (e.is_rd) begin
      chk({p, "_read_data"}, rdata_s[i], e.data);
      last_rd[i] = e.data;
    end else begin
      chk({p, "_rdata_hold_on_write"}, rdata_s[i], last_rd[i]);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_s[i]) last_rd[i] = '0;
      else if (ack_s[i]) mon_ack(i);
    end
  end

  // Issue one request from a negedge; returns at a negedge with the DUT idle.
  task automatic req(input int i, input logic wr, input logic rd, input logic [3:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    int  n;
    sb_t e;
    n = 0;
    while (busy_s[i] && n < 50) begin @(negedge clk); n++; end
    chk("idle_before_req", busy_s[i], 0);
    addr_s[i] = a; wd_s[i] = d; be_s[i] = be; wr_s[i] = wr; rd_s[i] = rd;
    e.is_rd   = rd && !wr;
    e.ack_cyc = cyc + 1 + ws(i);
    if (wr) mdl[i][a] = merge(mdl[i][a], d, be);
    e.data = mdl[i][a];
    push(i, e);
    @(negedge clk);
    wr_s[i] = 1'b0; rd_s[i] = 1'b0;
    n = 0;
    while (busy_s[i] && n < 50) begin n++; @(negedge clk); end
    chk("busy_cycles", n, ws(i) + 1);
  endtask

  initial begin
    int  acc;
    sb_t e;
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b1; addr_s[i] = '0; wd_s[i] = '0; rd_s[i] = 1'b0;
      wr_s[i] = 1'b0; be_s[i] = '0;
      for (int k = 0; k < 16; k++) mdl[i][k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_ack", ack_s[i], 0);
      chk("reset_busy", busy_s[i], 0);
      chk("reset_rdata", rdata_s[i], 0);
      rst_s[i] = 1'b0;
    end
    @(negedge clk);

    // 1: read after reset
    req(0, 0, 1, 4'd3, 32'h0, 4'h0);
    // 2: full write then readback, both wait-state settings
    for (int i = 0; i < 2; i++) begin
      req(i, 1, 0, 4'd5, 32'hDEADBEEF, 4'hF);
      req(i, 0, 1, 4'd5, 32'h0, 4'h0);
    end
    // 3: partial byte write, then empty byte_en write
    req(0, 1, 0, 4'd5, 32'h11223344, 4'b0101);
    req(0, 0, 1, 4'd5, 32'h0, 4'h0);
    req(0, 1, 0, 4'd5, 32'hFFFFFFFF, 4'b0000);
    req(0, 0, 1, 4'd5, 32'h0, 4'h0);
    req(1, 1, 0, 4'd15, 32'hCAFEF00D, 4'b1000);
    req(1, 0, 1, 4'd15, 32'h0, 4'h0);
    req(0, 1, 0, 4'd6, 32'h66666666, 4'hF);

    // 4: continuous read strobe, address changed mid-WAIT
    acc = cyc + 1;
    addr_s[0] = 4'd5; rd_s[0] = 1'b1;
    e.is_rd = 1'b1; e.data = mdl[0][5];
    e.ack_cyc = acc + 2; push(0, e);
    e.ack_cyc = acc + 6; push(0, e);
    while (cyc != acc + 4) @(negedge clk);
    addr_s[0] = 4'd6;
    e.data = mdl[0][6]; e.ack_cyc = acc + 10; push(0, e);
    while (cyc != acc + 8) @(negedge clk);
    rd_s[0] = 1'b0;
    while (cyc != acc + 11) @(negedge clk);

    // 5: both strobes -> write
    req(0, 1, 1, 4'd0, 32'hA5A5A5A5, 4'hF);
    req(0, 0, 1, 4'd0, 32'h0, 4'h0);

    // 6: reset during WAIT of a write
    addr_s[0] = 4'd7; wd_s[0] = 32'h12345678; be_s[0] = 4'hF; wr_s[0] = 1'b1;
    @(negedge clk);
    wr_s[0] = 1'b0;
    chk("t6_busy_in_wait", busy_s[0], 1);
    rst_s[0] = 1'b1;
    @(negedge clk);
    chk("t6_ack_after_reset", ack_s[0], 0);
    chk("t6_busy_after_reset", busy_s[0], 0);
    rst_s[0] = 1'b0;
    for (int k = 0; k < 16; k++) mdl[0][k] = '0;
    @(negedge clk);
    req(0, 0, 1, 4'd7, 32'h0, 4'h0);

    repeat (4) @(negedge clk);
    chk("sb_a_drained", sb0.size(), 0);
    chk("sb_b_drained", sb1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
